// File: rtl/hero_write_packer.sv
//==============================================================================
// Module      : hero_write_packer
// Description : Packs a stream of single hero writes, each tagged with a
//               cycle type (IDLE / VALID / DONE / reserved), into one bundle
//               of up to NUM_ENTRIES writes. Valid/ready handshake on both
//               the input beat side and the output bundle side.
//
//               Optional feature macro: HERO_PACKER_TIMEOUT_EN
//                 defined   -> a partial bundle is flushed after TIMEOUT_CYC
//                              FILL cycles without an accepted VALID beat.
//                 undefined -> no idle counter; a partial bundle waits
//                              indefinitely for DONE or for the last slot.
//
// Ports       : clk              clock, rising edge
//               rst              asynchronous reset, active high
//               in_valid_i       input beat valid
//               in_ready_o       input beat accepted when valid & ready
//               in_cycle_type_i  0=IDLE 1=VALID 2=DONE 3=reserved
//               in_data_i        hero write (meaningful on VALID beats)
//               out_valid_o      bundle available
//               out_ready_i      bundle consumed when valid & ready
//               out_data_o       entry i at [i*WR_W +: WR_W], unused = 0
//               out_count_o      number of valid entries in the bundle
//               out_done_o       1 = closed by DONE, 0 = full / timeout
//               err_reserved_o   one-cycle pulse per accepted reserved beat
//
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module hero_write_packer #(
    parameter int WR_W        = 16,
    parameter int NUM_ENTRIES = 4,
    parameter int TIMEOUT_CYC = 8,
    localparam int CNT_W      = $clog2(NUM_ENTRIES + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [1:0]                    in_cycle_type_i,
    input  logic [WR_W-1:0]               in_data_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [NUM_ENTRIES*WR_W-1:0]   out_data_o,
    output logic [CNT_W-1:0]              out_count_o,
    output logic                          out_done_o,
    output logic                          err_reserved_o
);

    localparam logic [1:0] CT_IDLE  = 2'd0;
    localparam logic [1:0] CT_VALID = 2'd1;
    localparam logic [1:0] CT_DONE  = 2'd2;

    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NUM_ENTRIES - 1);

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    // Elaboration-time sanity check on the configuration.
    if (NUM_ENTRIES < 2 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("hero_write_packer: NUM_ENTRIES must be >= 2 and TIMEOUT_CYC >= 1");
    end

    state_t                        state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [NUM_ENTRIES*WR_W-1:0]   data_q, data_d;
    logic                          valid_q, valid_d;
    logic                          done_q, done_d;
    logic                          err_q, err_d;

    logic                          accept;
    logic                          accept_valid;

`ifdef HERO_PACKER_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

    logic [IDLE_W-1:0]             idle_q, idle_d;
`endif

    // Ready depends on state only, so it never combinationally follows
    // in_valid_i or out_ready_i.
    assign in_ready_o   = (state_q == S_FILL);
    assign accept       = in_valid_i && in_ready_o;
    assign accept_valid = accept && (in_cycle_type_i == CT_VALID);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        done_d  = done_q;
        err_d   = 1'b0;
`ifdef HERO_PACKER_TIMEOUT_EN
        idle_d  = idle_q;
`endif

        case (state_q)
            S_FILL: begin
                if (accept) begin
                    case (in_cycle_type_i)
                        CT_VALID: begin
                            for (int i = 0; i < NUM_ENTRIES; i++) begin
                                if (cnt_q == CNT_W'(i)) begin
                                    data_d[i*WR_W +: WR_W] = in_data_i;
                                end
                            end
                            cnt_d = cnt_q + 1'b1;
                            if (cnt_q == LAST_SLOT) begin
                                state_d = S_HOLD;
                                valid_d = 1'b1;
                                done_d  = 1'b0;
                            end
                        end
                        CT_DONE: begin
                            // DONE on an empty bundle carries no data: drop it.
                            if (cnt_q != '0) begin
                                state_d = S_HOLD;
                                valid_d = 1'b1;
                                done_d  = 1'b1;
                            end
                        end
                        CT_IDLE: begin
                        end
                        default: begin
                            // Reserved encoding behaves as IDLE but is flagged.
                            err_d = 1'b1;
                        end
                    endcase
                end

`ifdef HERO_PACKER_TIMEOUT_EN
                if (accept_valid) begin
                    idle_d = '0;
                end else if (cnt_q != '0 && state_d == S_FILL) begin
                    idle_d = idle_q + 1'b1;
                    if (idle_q == IDLE_LAST) begin
                        state_d = S_HOLD;
                        valid_d = 1'b1;
                        done_d  = 1'b0;
                    end
                end
`endif
            end

            S_HOLD: begin
                if (out_ready_i) begin
                    state_d = S_FILL;
                    cnt_d   = '0;
                    data_d  = '0;
                    valid_d = 1'b0;
                    done_d  = 1'b0;
`ifdef HERO_PACKER_TIMEOUT_EN
                    idle_d  = '0;
`endif
                end
            end

            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FILL;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef HERO_PACKER_TIMEOUT_EN
            idle_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef HERO_PACKER_TIMEOUT_EN
            idle_q  <= idle_d;
`endif
        end
    end

    // Storage is zeroed on every handshake, so unused entries read as zero.
    assign out_valid_o    = valid_q;
    assign out_data_o     = data_q;
    assign out_count_o    = cnt_q;
    assign out_done_o     = done_q;
    assign err_reserved_o = err_q;

endmodule

`default_nettype wire

// File: tb/tb_hero_write_packer.sv
//==============================================================================
// Module      : tb_hero_write_packer
// Description : Directed, self-checking bench for hero_write_packer. A small
//               packing model pushes expected bundles into a queue as beats
//               are driven; bundles are popped and compared as they appear.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_hero_write_packer;

    localparam int WR_W  = 16;
    localparam int N     = 4;
    localparam int TO    = 8;
    localparam int CW    = $clog2(N + 1);
    localparam int DW    = N * WR_W;

    localparam logic [1:0] CT_IDLE  = 2'd0;
    localparam logic [1:0] CT_VALID = 2'd1;
    localparam logic [1:0] CT_DONE  = 2'd2;
    localparam logic [1:0] CT_RSV   = 2'd3;

    typedef struct {
        logic [DW-1:0] data;
        logic [CW-1:0] count;
        logic          done;
    } bundle_t;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_cycle_type;
    logic [WR_W-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [CW-1:0]   out_count;
    logic            out_done;
    logic            err_reserved;

    int n_assert;
    int n_fail;

    bundle_t         sb[$];
    logic [DW-1:0]   m_data;
    int              m_cnt;

    hero_write_packer #(
        .WR_W        (WR_W),
        .NUM_ENTRIES (N),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready),
        .in_cycle_type_i (in_cycle_type),
        .in_data_i       (in_data),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .out_data_o      (out_data),
        .out_count_o     (out_count),
        .out_done_o      (out_done),
        .err_reserved_o  (err_reserved)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_data = '0;
        m_cnt  = 0;
    endtask

    task automatic model_push(input logic done);
        bundle_t b;
        b.data  = m_data;
        b.count = CW'(m_cnt);
        b.done  = done;
        sb.push_back(b);
        model_clear();
    endtask

    // Drives one beat starting at a negedge; returns at the following negedge
    // with the result of the accepting edge visible.
    task automatic beat(input logic [1:0] ct, input logic [WR_W-1:0] d);
        int w;
        in_valid      = 1'b1;
        in_cycle_type = ct;
        in_data       = d;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) chk("in_ready_wait", in_ready, 1);
        case (ct)
            CT_VALID: begin
                m_data[m_cnt*WR_W +: WR_W] = d;
                m_cnt++;
                if (m_cnt == N) model_push(1'b0);
            end
            CT_DONE: if (m_cnt > 0) model_push(1'b1);
            default: ;
        endcase
        @(negedge clk);
        in_valid      = 1'b0;
        in_cycle_type = CT_IDLE;
        in_data       = '0;
    endtask

    task automatic check_bundle(input int budget, input int hold);
        int            w;
        bundle_t       e;
        logic [DW-1:0] snap_d;
        logic [CW-1:0] snap_c;
        logic          snap_n;
        w = 0;
        while (!out_valid && w < budget) begin
            @(negedge clk);
            w++;
        end
        chk("bundle_valid", out_valid, 1);
        chk("sb_nonempty", (sb.size() != 0), 1);
        if (out_valid && sb.size() != 0) begin
            e = sb.pop_front();
            chk("bundle_data", out_data, e.data);
            chk("bundle_count", out_count, e.count);
            chk("bundle_done", out_done, e.done);
            chk("hold_in_ready", in_ready, 0);
            snap_d = out_data;
            snap_c = out_count;
            snap_n = out_done;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("hold_stable", {out_valid, in_ready, out_data, out_count, out_done},
                                   {1'b1, 1'b0, snap_d, snap_c, snap_n});
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_hs_valid", out_valid, 0);
        chk("post_hs_ready", in_ready, 1);
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        chk(tag, seen, 0);
    endtask

    initial begin
        n_assert      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        in_valid      = 1'b0;
        in_cycle_type = CT_IDLE;
        in_data       = '0;
        out_ready     = 1'b0;
        model_clear();

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_err", err_reserved, 0);
        chk("rst_out_done", out_done, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        // Full bundle: out_valid exactly one cycle after the last beat
        beat(CT_VALID, 16'h0011);
        beat(CT_VALID, 16'h0022);
        beat(CT_VALID, 16'h0033);
        beat(CT_VALID, 16'h0044);
        chk("fill_literal", out_data, 64'h0044_0033_0022_0011);
        check_bundle(0, 0);

        // Partial bundle closed by DONE, with 10 cycles of backpressure
        beat(CT_VALID, 16'hAAAA);
        beat(CT_IDLE, 16'h0000);
        beat(CT_DONE, 16'h0000);
        check_bundle(0, 10);

        // Lone DONE with an empty bundle is dropped
        beat(CT_DONE, 16'h0000);
        expect_quiet("lone_done_quiet", 5);

        // Reserved beat: error pulse, count unaffected
        beat(CT_VALID, 16'h1234);
        beat(CT_RSV, 16'hDEAD);
        chk("rsv_pulse", err_reserved, 1);
        @(negedge clk);
        chk("rsv_pulse_end", err_reserved, 0);
        beat(CT_VALID, 16'h5678);
        beat(CT_DONE, 16'h0000);
        check_bundle(0, 0);

        // Full bundle, then DONE: DONE falls into a fresh empty bundle
        beat(CT_VALID, 16'h0101);
        beat(CT_VALID, 16'h0202);
        beat(CT_VALID, 16'h0303);
        beat(CT_VALID, 16'h0404);
        check_bundle(0, 0);
        beat(CT_DONE, 16'h0000);
        expect_quiet("done_after_full_quiet", 4);

        // Reset mid-FILL after two VALIDs
        beat(CT_VALID, 16'h0001);
        beat(CT_VALID, 16'h0002);
        #2 rst = 1'b1;
        #1;
        chk("midfill_rst_count", out_count, 0);
        chk("midfill_rst_data", out_data, 0);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        beat(CT_DONE, 16'h0000);
        expect_quiet("post_rst_done_quiet", 5);

        // Reset while a full bundle is held
        beat(CT_VALID, 16'h0A0A);
        beat(CT_VALID, 16'h0B0B);
        beat(CT_VALID, 16'h0C0C);
        beat(CT_VALID, 16'h0D0D);
        chk("midhold_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("midhold_rst", {out_valid, out_count, out_data}, '0);
        void'(sb.pop_front());
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        chk("midhold_rst_ready", in_ready, 1);

        // Idle timeout behaviour
        beat(CT_VALID, 16'h0005);
`ifdef HERO_PACKER_TIMEOUT_EN
        for (int i = 0; i < TO - 1; i++) beat(CT_IDLE, 16'h0000);
        chk("timeout_early", out_valid, 0);
        beat(CT_IDLE, 16'h0000);
        model_push(1'b0);
        check_bundle(0, 0);
`else
        expect_quiet("no_timeout_quiet", 100);
        beat(CT_DONE, 16'h0000);
        check_bundle(0, 0);
`endif

        chk("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
